parking_gate_arbiter: RTL and testbench

Sequences the single motorised parking gate that entering and exiting cars share. It arbitrates between the entry and exit sensors, drives the gate motor through open, hold and close phases using the limit switches, and keeps the registered occupancy count. It sits between the raw car/limit sensors and the gate motor driver. Its occupancy, full and fault outputs feed the shop-level status logic.

---
 rtl/parking_gate_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// Purpose: sequences the shared parking gate, arbitrating entry/exit cars and tracking occupancy.
// Latency: a grant and the motor drive appear one cycle after the request is sampled; all outputs are registered.
// Backpressure: requests are level inputs that are not queued; they are re-evaluated each time the gate is idle.
module parking_gate_arbiter #(
  parameter int CAPACITY       = 5,
  parameter int CNT_W          = 8,
  parameter int HOLD_CYCLES    = 10,
  parameter int MOTION_TIMEOUT = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             car_entry_req,
  input  logic             car_exit_req,
  input  logic             car_passed,
  input  logic             gate_max,
  input  logic             gate_min,
  input  logic             fault_clear,
  output logic             gate_open,
  output logic             gate_close,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             fault
);

  localparam int TMR_W = $clog2(MOTION_TIMEOUT + 1);
  localparam int HLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(MOTION_TIMEOUT - 1);
  localparam logic [HLD_W-1:0] HOLD_LOAD = HLD_W'(HOLD_CYCLES);
  localparam logic [HLD_W-1:0] HOLD_ONE  = HLD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPENING,
    S_HOLD,
    S_CLOSING,
    S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [HLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   occupancy_q, occupancy_d;
  logic               counted_q, counted_d;     // pass already counted in this gate cycle
  logic               last_exit_q, last_exit_d; // 1: exit won the most recent tie
  logic               gate_open_q, gate_open_d;
  logic               gate_close_q, gate_close_d;
  logic               entry_grant_q, entry_grant_d;
  logic               exit_grant_q, exit_grant_d;
  logic               fault_q, fault_d;

  logic entry_elig;
  logic exit_elig;
  logic limit_conflict;

  assign entry_elig     = car_entry_req && (occupancy_q < CAP);
  assign exit_elig      = car_exit_req && (occupancy_q != '0);
  assign limit_conflict = gate_max && gate_min;

  // Next-state, timers, occupancy and the registered (Moore) output values.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    hold_d        = hold_q;
    occupancy_d   = occupancy_q;
    counted_d     = counted_q;
    last_exit_d   = last_exit_q;
    entry_grant_d = entry_grant_q;
    exit_grant_d  = exit_grant_q;

    case (state_q)
      S_IDLE: begin
        timer_d   = '0;
        counted_d = 1'b0;
        if (entry_elig && exit_elig) begin
          // Round-robin only decides ties; single-sided grants leave the pointer alone.
          entry_grant_d = last_exit_q;
          exit_grant_d  = !last_exit_q;
          last_exit_d   = !last_exit_q;
          state_d       = S_OPENING;
        end else if (entry_elig) begin
          entry_grant_d = 1'b1;
          state_d       = S_OPENING;
        end else if (exit_elig) begin
          exit_grant_d = 1'b1;
          state_d      = S_OPENING;
        end
      end

      S_OPENING: begin
        if (limit_conflict) begin
          state_d = S_FAULT;
        end else if (gate_max) begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (limit_conflict) begin
          state_d = S_FAULT;
        end else if (car_passed) begin
          hold_d = HOLD_LOAD;
          if (!counted_q) begin
            counted_d = 1'b1;
            if (entry_grant_q && (occupancy_q < CAP)) begin
              occupancy_d = occupancy_q + 1'b1;
            end else if (exit_grant_q && (occupancy_q != '0)) begin
              occupancy_d = occupancy_q - 1'b1;
            end
          end
        end else if (hold_q <= HOLD_ONE) begin
          state_d = S_CLOSING;
          timer_d = '0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end

      S_CLOSING: begin
        if (limit_conflict) begin
          state_d = S_FAULT;
        end else if (gate_min) begin
          state_d = S_IDLE;
        end else if (car_passed) begin
          // Obstruction: reopen for the same car; its pass is already counted.
          state_d = S_OPENING;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_FAULT: begin
        if (fault_clear) begin
          timer_d = '0;
          state_d = gate_min ? S_IDLE : S_CLOSING;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Grants live only for a gate cycle; a fault or the return to idle drops them.
    if ((state_d == S_IDLE) || (state_d == S_FAULT)) begin
      entry_grant_d = 1'b0;
      exit_grant_d  = 1'b0;
    end

    gate_open_d  = (state_d == S_OPENING);
    gate_close_d = (state_d == S_CLOSING);
    fault_d      = (state_d == S_FAULT);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      hold_q        <= '0;
      occupancy_q   <= '0;
      counted_q     <= 1'b0;
      last_exit_q   <= 1'b1;
      gate_open_q   <= 1'b0;
      gate_close_q  <= 1'b0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      hold_q        <= hold_d;
      occupancy_q   <= occupancy_d;
      counted_q     <= counted_d;
      last_exit_q   <= last_exit_d;
      gate_open_q   <= gate_open_d;
      gate_close_q  <= gate_close_d;
      entry_grant_q <= entry_grant_d;
      exit_grant_q  <= exit_grant_d;
      fault_q       <= fault_d;
    end
  end

  assign gate_open   = gate_open_q;
  assign gate_close  = gate_close_q;
  assign entry_grant = entry_grant_q;
  assign exit_grant  = exit_grant_q;
  assign occupancy   = occupancy_q;
  assign full        = (occupancy_q == CAP);
  assign fault       = fault_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: the bench plays the gate mechanism and the cars.
// Expected grants/occupancy come from a transaction-level model (count + tie pointer).
module tb_parking_gate_arbiter;

  localparam int CAPACITY       = 5;
  localparam int CNT_W          = 8;
  localparam int HOLD_CYCLES    = 10;
  localparam int MOTION_TIMEOUT = 50;

  logic             clk = 1'b0;
  logic             rst;
  logic             car_entry_req, car_exit_req, car_passed;
  logic             gate_max, gate_min, fault_clear;
  logic             gate_open, gate_close, entry_grant, exit_grant;
  logic [CNT_W-1:0] occupancy;
  logic             full, fault;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: cars parked, and which side won the last tie.
  int model_occ;
  bit model_last_exit;

  parking_gate_arbiter #(
    .CAPACITY(CAPACITY), .CNT_W(CNT_W),
    .HOLD_CYCLES(HOLD_CYCLES), .MOTION_TIMEOUT(MOTION_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .car_entry_req(car_entry_req), .car_exit_req(car_exit_req),
    .car_passed(car_passed), .gate_max(gate_max), .gate_min(gate_min),
    .fault_clear(fault_clear),
    .gate_open(gate_open), .gate_close(gate_close),
    .entry_grant(entry_grant), .exit_grant(exit_grant),
    .occupancy(occupancy), .full(full), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    car_entry_req = 0; car_exit_req = 0; car_passed = 0;
    gate_max = 0; gate_min = 0; fault_clear = 0;
    tick(); tick();
    rst = 1'b0;
    model_occ = 0;
    model_last_exit = 1'b1;
    tests_run++;
    if ({gate_open, gate_close, entry_grant, exit_grant, full, fault} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {gate_open, gate_close, entry_grant, exit_grant, full, fault});
    end
    tests_run++;
    if (occupancy !== '0) begin
      tests_failed++;
      $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
    end
  endtask

  // One complete gate cycle. p1/p2: hold-cycle indices of car_passed pulses (-1 = none);
  // obs: closing-cycle index of an obstruction pulse (-1 = none).
  task automatic serve_car(input bit ereq, input bit xreq, input int open_dly,
                           input int p1, input int p2, input int obs,
                           input int close_dly, input string tag);
    bit e_ok, x_ok, exp_e, exp_x;
    int hold_len, last_pass;
    e_ok = ereq && (model_occ < CAPACITY);
    x_ok = xreq && (model_occ > 0);
    if (e_ok && x_ok) begin
      exp_e = model_last_exit;
      exp_x = !model_last_exit;
      model_last_exit = exp_x;
    end else begin
      exp_e = e_ok;
      exp_x = x_ok;
    end

    car_entry_req = ereq; car_exit_req = xreq;
    tick();
    car_entry_req = 0; car_exit_req = 0;
    tests_run++;
    if ({gate_open, gate_close, entry_grant, exit_grant} !== {exp_e | exp_x, 1'b0, exp_e, exp_x}) begin
      tests_failed++;
      $display("FAIL %s grant: got open/close/eg/xg=%b expected %b", tag,
               {gate_open, gate_close, entry_grant, exit_grant}, {exp_e | exp_x, 1'b0, exp_e, exp_x});
    end
    if (!(exp_e || exp_x)) begin
      tick();
      tests_run++;
      if ({gate_open, gate_close, entry_grant, exit_grant} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL %s refused: got %b expected 0000", tag,
                 {gate_open, gate_close, entry_grant, exit_grant});
      end
      return;
    end

    // Opening: gate_open is seen for open_dly+1 cycles.
    for (int i = 0; i < open_dly; i++) begin
      tick();
      tests_run++;
      if ({gate_open, gate_close, entry_grant, exit_grant} !== {2'b10, exp_e, exp_x}) begin
        tests_failed++;
        $display("FAIL %s opening[%0d]: got %b expected %b", tag, i,
                 {gate_open, gate_close, entry_grant, exit_grant}, {2'b10, exp_e, exp_x});
      end
    end
    gate_max = 1; tick(); gate_max = 0;

    // Hold: lasts HOLD_CYCLES after entry, or after the last pass.
    last_pass = (p2 >= 0) ? p2 : p1;
    hold_len  = (p1 < 0) ? HOLD_CYCLES : last_pass + 1 + HOLD_CYCLES;
    for (int c = 0; c < hold_len; c++) begin
      tests_run++;
      if ({gate_open, gate_close, entry_grant, exit_grant} !== {2'b00, exp_e, exp_x}) begin
        tests_failed++;
        $display("FAIL %s hold[%0d]: got %b expected %b", tag, c,
                 {gate_open, gate_close, entry_grant, exit_grant}, {2'b00, exp_e, exp_x});
      end
      car_passed = (c == p1) || (c == p2);
      tick();
      car_passed = 0;
    end
    if (p1 >= 0) model_occ = model_occ + (exp_e ? 1 : -1);
    tests_run++;
    if (occupancy !== CNT_W'(model_occ)) begin
      tests_failed++;
      $display("FAIL %s occupancy: got %0d expected %0d", tag, occupancy, model_occ);
    end

    // Optional obstruction during closing: reopen, hold again, close again.
    if (obs >= 0) begin
      for (int i = 0; i <= obs; i++) begin
        tests_run++;
        if ({gate_open, gate_close} !== 2'b01) begin
          tests_failed++;
          $display("FAIL %s closing_pre[%0d]: got %b expected 01", tag, i, {gate_open, gate_close});
        end
        car_passed = (i == obs);
        tick();
        car_passed = 0;
      end
      tests_run++;
      if ({gate_open, gate_close, entry_grant, exit_grant} !== {2'b10, exp_e, exp_x}) begin
        tests_failed++;
        $display("FAIL %s reopen: got %b expected %b", tag,
                 {gate_open, gate_close, entry_grant, exit_grant}, {2'b10, exp_e, exp_x});
      end
      gate_max = 1; tick(); gate_max = 0;
      for (int c = 0; c < HOLD_CYCLES; c++) begin
        tests_run++;
        if ({gate_open, gate_close} !== 2'b00) begin
          tests_failed++;
          $display("FAIL %s rehold[%0d]: got %b expected 00", tag, c, {gate_open, gate_close});
        end
        tick();
      end
    end

    for (int i = 0; i < close_dly; i++) begin
      tests_run++;
      if ({gate_open, gate_close, entry_grant, exit_grant} !== {2'b01, exp_e, exp_x}) begin
        tests_failed++;
        $display("FAIL %s closing[%0d]: got %b expected %b", tag, i,
                 {gate_open, gate_close, entry_grant, exit_grant}, {2'b01, exp_e, exp_x});
      end
      tick();
    end
    tests_run++;
    if (gate_close !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s closing_last: got gate_close=%b expected 1", tag, gate_close);
    end
    gate_min = 1; tick(); gate_min = 0;
    tests_run++;
    if ({gate_open, gate_close, entry_grant, exit_grant, fault} !== 5'b0 ||
        occupancy !== CNT_W'(model_occ) || full !== (model_occ == CAPACITY)) begin
      tests_failed++;
      $display("FAIL %s end: got ctl=%b occ=%0d full=%b expected ctl=00000 occ=%0d full=%b", tag,
               {gate_open, gate_close, entry_grant, exit_grant, fault}, occupancy, full,
               model_occ, model_occ == CAPACITY);
    end
  endtask

  task automatic test_exit_when_empty();
    serve_car(1'b0, 1'b1, 0, -1, -1, -1, 0, "exit_empty");
  endtask

  task automatic test_entry();
    serve_car(1'b1, 1'b0, 3, 0, -1, -1, 4, "entry");
  endtask

  task automatic test_tie();
    serve_car(1'b1, 1'b0, 1, 2, -1, -1, 2, "tie_fill");
    serve_car(1'b1, 1'b1, 2, 1, -1, -1, 1, "tie1");
    serve_car(1'b1, 1'b1, 0, 0, 4, -1, 3, "tie2");
    tests_run++;
    if (occupancy !== CNT_W'(2)) begin
      tests_failed++;
      $display("FAIL tie_occ_back: got %0d expected 2", occupancy);
    end
    serve_car(1'b1, 1'b1, 1, 5, -1, -1, 0, "tie3");
  endtask

  task automatic test_obstruction();
    serve_car(1'b0, 1'b1, 2, 3, -1, 1, 2, "obstruct");
  endtask

  task automatic test_full();
    while (model_occ < CAPACITY) serve_car(1'b1, 1'b0, 1, 0, -1, -1, 1, "fill");
    tests_run++;
    if (full !== 1'b1 || occupancy !== CNT_W'(CAPACITY)) begin
      tests_failed++;
      $display("FAIL full_flag: got full=%b occ=%0d expected full=1 occ=%0d", full, occupancy, CAPACITY);
    end
    serve_car(1'b1, 1'b0, 0, -1, -1, -1, 0, "entry_at_full");
  endtask

  task automatic test_timeout();
    car_exit_req = 1; tick(); car_exit_req = 0;
    for (int i = 1; i < MOTION_TIMEOUT; i++) tick();
    tests_run++;
    if ({gate_open, fault} !== 2'b10) begin
      tests_failed++;
      $display("FAIL timeout_last_open: got open/fault=%b expected 10", {gate_open, fault});
    end
    tick();
    car_entry_req = 1; car_exit_req = 1;
    tests_run++;
    if ({gate_open, gate_close, entry_grant, exit_grant, fault} !== 5'b00001) begin
      tests_failed++;
      $display("FAIL timeout_fault: got %b expected 00001",
               {gate_open, gate_close, entry_grant, exit_grant, fault});
    end
    tick(); tick();
    tests_run++;
    if ({gate_open, gate_close, entry_grant, exit_grant, fault} !== 5'b00001) begin
      tests_failed++;
      $display("FAIL fault_ignores_req: got %b expected 00001",
               {gate_open, gate_close, entry_grant, exit_grant, fault});
    end
    car_entry_req = 0; car_exit_req = 0;
    fault_clear = 1; tick(); fault_clear = 0;
    tests_run++;
    if ({gate_open, gate_close, entry_grant, exit_grant, fault} !== 5'b01000) begin
      tests_failed++;
      $display("FAIL fault_clear_closing: got %b expected 01000",
               {gate_open, gate_close, entry_grant, exit_grant, fault});
    end
    gate_min = 1; tick(); gate_min = 0;
    tests_run++;
    if ({gate_open, gate_close, fault} !== 3'b000 || occupancy !== CNT_W'(model_occ)) begin
      tests_failed++;
      $display("FAIL timeout_recover: got ctl=%b occ=%0d expected ctl=000 occ=%0d",
               {gate_open, gate_close, fault}, occupancy, model_occ);
    end
  endtask

  task automatic test_limit_conflict();
    car_exit_req = 1; tick(); car_exit_req = 0;
    gate_max = 1; gate_min = 1; tick(); gate_max = 0;
    tests_run++;
    if ({gate_open, gate_close, entry_grant, exit_grant, fault} !== 5'b00001) begin
      tests_failed++;
      $display("FAIL conflict_fault: got %b expected 00001",
               {gate_open, gate_close, entry_grant, exit_grant, fault});
    end
    fault_clear = 1; tick(); fault_clear = 0; gate_min = 0;
    tests_run++;
    if ({gate_open, gate_close, entry_grant, exit_grant, fault} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL conflict_clear_idle: got %b expected 00000",
               {gate_open, gate_close, entry_grant, exit_grant, fault});
    end
  endtask

  task automatic test_reset_mid_hold();
    while (model_occ > 3) serve_car(1'b0, 1'b1, 1, 1, -1, -1, 1, "drain");
    car_entry_req = 1; tick(); car_entry_req = 0;
    gate_max = 1; tick(); gate_max = 0;
    tick(); tick();
    tests_run++;
    if ({gate_open, gate_close, entry_grant, exit_grant} !== 4'b0010 || occupancy !== CNT_W'(3)) begin
      tests_failed++;
      $display("FAIL pre_reset_hold: got ctl=%b occ=%0d expected ctl=0010 occ=3",
               {gate_open, gate_close, entry_grant, exit_grant}, occupancy);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({gate_open, gate_close, entry_grant, exit_grant, full, fault} !== 6'b0 || occupancy !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got ctl=%b occ=%0d expected ctl=000000 occ=0",
               {gate_open, gate_close, entry_grant, exit_grant, full, fault}, occupancy);
    end
    tick();
    rst = 1'b0;
    model_occ = 0;
    model_last_exit = 1'b1;
    serve_car(1'b1, 1'b0, 0, 0, -1, -1, 1, "post_reset_entry");
    serve_car(1'b1, 1'b1, 0, 0, -1, -1, 1, "post_reset_tie");
  endtask

  task automatic test_random();
    bit ereq, xreq;
    int np, p1, p2, obs;
    for (int t = 0; t < 40; t++) begin
      ereq = ($urandom_range(0, 3) != 0);
      xreq = ($urandom_range(0, 1) == 1);
      np   = $urandom_range(0, 2);
      p1   = (np > 0) ? $urandom_range(0, HOLD_CYCLES - 1) : -1;
      p2   = (np > 1) ? p1 + $urandom_range(1, HOLD_CYCLES) : -1;
      obs  = (np > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      serve_car(ereq, xreq, $urandom_range(0, 6), p1, p2, obs, $urandom_range(0, 5), "random");
    end
  endtask

  initial begin
    test_reset();
    test_exit_when_empty();
    test_entry();
    test_tie();
    test_obstruction();
    test_full();
    test_timeout();
    test_limit_conflict();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
